proc_datapath: RTL and testbench

- Processor datapath driven cycle-by-cycle by the control FSM; it is the stage directly downstream of that FSM.
- Holds R0–R6, the PC (R7), and the IR, A, G, ADDR and DOUT registers, plus the Z/N flags.
- Contains the 16-bit shared bus mux and the ALU.
- Returns ir and btrue to the FSM; drives the address, write data and write enable of the synchronous memory.

---
 rtl/proc_pkg.sv | 38 +++
 rtl/proc_if.sv | 29 ++
 rtl/proc_alu.sv | 30 +++
 rtl/proc_datapath.sv | 103 ++++++++++
 tb/tb_proc_datapath.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the processor datapath: bus-source, ALU and branch codes plus opcodes.
package proc_pkg;

  localparam logic [3:0] SEL_IMM = 4'b0000;
  localparam logic [3:0] SEL_DIN = 4'b0111;
  localparam logic [3:0] SEL_PC  = 4'b1000;
  localparam logic [3:0] SEL_G   = 4'b1001;
  localparam logic [3:0] SEL_RX  = 4'b1011;
  localparam logic [3:0] SEL_RY  = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;

  localparam logic [1:0] BOP_ALWAYS = 2'b00;
  localparam logic [1:0] BOP_EQ     = 2'b01;
  localparam logic [1:0] BOP_NE     = 2'b10;
  localparam logic [1:0] BOP_NEVER  = 2'b11;

  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVT = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b0111;
  localparam logic [3:0] OP_LDO = 4'b1000;
  localparam logic [3:0] OP_STO = 4'b1001;

  // Branch and offset load/store carry a signed immediate; everything else is unsigned.
  function automatic logic imm_signed(input logic [3:0] op);
    return (op == OP_B) || (op == OP_LDO) || (op == OP_STO);
  endfunction

endpackage

// File: rtl/proc_if.sv
// Control/status and memory-side signals between the control FSM and the datapath.
interface proc_if #(parameter int DW = 16);
  logic [DW-1:0] din;
  logic          ir_in;
  logic          r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in;
  logic          pc_in, pc_inc;
  logic [3:0]    select;
  logic          mvt, a_in, g_in;
  logic [2:0]    ula;
  logic [1:0]    bope;
  logic          addr_in, dout_in, wren;
  logic [DW-1:0] ir;
  logic          btrue;
  logic [DW-1:0] addr, dout;
  logic          w;
  logic [DW-1:0] bus;

  modport master (
    output din, ir_in, r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in,
           pc_in, pc_inc, select, mvt, a_in, g_in, ula, bope, addr_in, dout_in, wren,
    input  ir, btrue, addr, dout, w, bus
  );

  modport slave (
    input  din, ir_in, r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in,
           pc_in, pc_inc, select, mvt, a_in, g_in, ula, bope, addr_in, dout_in, wren,
    output ir, btrue, addr, dout, w, bus
  );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: result = a op b, with zero and negative indications of the result.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          neg
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DW-1];

endmodule

// File: rtl/proc_datapath.sv
// Processor datapath: register file with PC, IR/A/G/ADDR/DOUT, shared bus mux, ALU and Z/N flags.
module proc_datapath
  import proc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int IMM_W = 9
) (
  input  logic  clock,
  input  logic  resetn,
  proc_if.slave dp
);

  logic [DW-1:0] rf [8];  // rf[7] is the PC
  logic [DW-1:0] ir_q, a_q, g_q, addr_q, dout_q;
  logic          z_q, n_q;
  logic [DW-1:0] bus, alu_res;
  logic          alu_z, alu_n;
  logic [6:0]    r_ld;
  logic          pc_ld;

  logic signed [IMM_W-1:0] imm_s;
  logic signed [DW-1:0]    imm_sx;
  logic        [DW-1:0]    imm_zx;

  assign r_ld  = {dp.r6_in, dp.r5_in, dp.r4_in, dp.r3_in, dp.r2_in, dp.r1_in, dp.r0_in};
  assign pc_ld = dp.pc_in | dp.r7_in;

  assign imm_s  = $signed(ir_q[IMM_W-1:0]);
  assign imm_sx = DW'(imm_s);
  assign imm_zx = {{(DW-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};

  always_comb begin
    bus = '0;
    case (dp.select)
      SEL_IMM: begin
        if (dp.mvt)                           bus = {ir_q[7:0], {(DW-8){1'b0}}};
        else if (imm_signed(ir_q[DW-1 -: 4])) bus = $unsigned(imm_sx);
        else                                  bus = imm_zx;
      end
      SEL_DIN: bus = dp.din;
      SEL_PC:  bus = rf[7];
      SEL_G:   bus = g_q;
      SEL_RX:  bus = rf[ir_q[10:8]];
      SEL_RY:  bus = rf[ir_q[2:0]];
      default: bus = '0;
    endcase
  end

  proc_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (bus),
    .op     (dp.ula),
    .result (alu_res),
    .zero   (alu_z),
    .neg    (alu_n)
  );

  // All loads sample the pre-edge bus, so reading and writing one register in a cycle is safe.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (r_ld[i]) rf[i] <= bus;
      end
      if (pc_ld)            rf[7] <= bus;
      else if (dp.pc_inc)   rf[7] <= rf[7] + DW'(1);
      if (dp.ir_in)   ir_q   <= dp.din;
      if (dp.a_in)    a_q    <= bus;
      if (dp.addr_in) addr_q <= bus;
      if (dp.dout_in) dout_q <= bus;
      if (dp.g_in) begin
        g_q <= alu_res;
        z_q <= alu_z;
        n_q <= alu_n;
      end
    end
  end

  always_comb begin
    dp.btrue = 1'b0;
    case (dp.bope)
      BOP_ALWAYS: dp.btrue = 1'b1;
      BOP_EQ:     dp.btrue = z_q;
      BOP_NE:     dp.btrue = ~z_q;
      default:    dp.btrue = 1'b0;
    endcase
  end

  assign dp.ir   = ir_q;
  assign dp.addr = addr_q;
  assign dp.dout = dout_q;
  assign dp.w    = dp.wren;
  assign dp.bus  = bus;

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: hand-computed bus/register values checked with immediate assertions.
module tb_proc_datapath;
  import proc_pkg::*;

  logic clock = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  proc_if #(.DW(16)) dp ();

  proc_datapath #(.DW(16), .IMM_W(9)) dut (
    .clock  (clock),
    .resetn (resetn),
    .dp     (dp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp.din = '0; dp.ir_in = 0;
    dp.r0_in = 0; dp.r1_in = 0; dp.r2_in = 0; dp.r3_in = 0;
    dp.r4_in = 0; dp.r5_in = 0; dp.r6_in = 0; dp.r7_in = 0;
    dp.pc_in = 0; dp.pc_inc = 0; dp.select = SEL_IMM; dp.mvt = 0;
    dp.a_in = 0; dp.g_in = 0; dp.ula = ALU_ADD; dp.bope = BOP_ALWAYS;
    dp.addr_in = 0; dp.dout_in = 0; dp.wren = 0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    dp.din = v; dp.ir_in = 1; tick(); dp.ir_in = 0;
  endtask

  task automatic peek(input logic [3:0] sel, input logic [15:0] exp, input string tag);
    dp.select = sel; #1; chk(tag, dp.bus, exp);
  endtask

  // A must already hold the left operand; the immediate of ir_val is the right operand.
  task automatic alu_op(input logic [15:0] ir_val, input logic [2:0] op,
                        input logic [15:0] exp, input string tag);
    load_ir(ir_val);
    dp.select = SEL_IMM; dp.ula = op; dp.g_in = 1; tick(); dp.g_in = 0;
    peek(SEL_G, exp, tag);
  endtask

  initial begin
    idle();
    resetn = 1'b1;
    #1;
    chk("rst_ir", dp.ir, 16'h0000);
    chk("rst_addr", dp.addr, 16'h0000);
    chk("rst_dout", dp.dout, 16'h0000);
    chk("rst_btrue_always", {15'b0, dp.btrue}, 16'h0001);
    dp.bope = BOP_EQ; #1;
    chk("rst_btrue_eq", {15'b0, dp.btrue}, 16'h0000);
    dp.bope = BOP_ALWAYS;
    tick();
    resetn = 1'b0;
    tick();

    // mv r0,#5 ; A<=r0 ; G<=A+3 ; r0<=G
    load_ir(16'h0805);
    chk("ir_load", dp.ir, 16'h0805);
    dp.select = SEL_IMM; dp.r0_in = 1; tick(); dp.r0_in = 0;
    peek(SEL_RX, 16'h0005, "mv_r0");
    dp.a_in = 1; tick(); dp.a_in = 0;
    alu_op(16'h2803, ALU_ADD, 16'h0008, "add_g");
    dp.bope = BOP_NE; #1;
    chk("add_z0_ne", {15'b0, dp.btrue}, 16'h0001);
    dp.bope = BOP_ALWAYS;
    dp.r0_in = 1; tick(); dp.r0_in = 0;
    peek(SEL_RX, 16'h0008, "r0_from_g");

    // mvt r1,#AB
    load_ir(16'h11AB);
    dp.mvt = 1;
    peek(SEL_IMM, 16'hAB00, "mvt_bus");
    dp.r1_in = 1; tick(); dp.r1_in = 0; dp.mvt = 0;
    peek(SEL_RX, 16'hAB00, "mvt_r1");

    // sub to zero and branch conditions
    load_ir(16'h0007);
    dp.select = SEL_IMM; dp.a_in = 1; tick(); dp.a_in = 0;
    alu_op(16'h0007, ALU_SUB, 16'h0000, "sub_zero");
    dp.bope = BOP_EQ;    #1; chk("beq_taken", {15'b0, dp.btrue}, 16'h0001);
    dp.bope = BOP_NE;    #1; chk("bne_not", {15'b0, dp.btrue}, 16'h0000);
    dp.bope = BOP_NEVER; #1; chk("bnever", {15'b0, dp.btrue}, 16'h0000);
    dp.bope = BOP_ALWAYS;

    // remaining ALU ops with A=7
    alu_op(16'h0005, ALU_AND, 16'h0005, "and");
    alu_op(16'h0004, ALU_SLL, 16'h0070, "sll");
    alu_op(16'h0001, ALU_SRL, 16'h0003, "srl");
    alu_op(16'h0008, ALU_SUB, 16'hFFFF, "sub_wrap");
    alu_op(16'h0002, 3'b101, 16'h0000, "alu_undef");
    dp.bope = BOP_EQ; #1; chk("undef_z", {15'b0, dp.btrue}, 16'h0001);
    dp.bope = BOP_ALWAYS;

    // branch offset: PC=0010, offset -2
    load_ir(16'h0010);
    dp.select = SEL_IMM; dp.pc_in = 1; tick(); dp.pc_in = 0;
    peek(SEL_PC, 16'h0010, "pc_set");
    load_ir(16'h71FE);
    dp.select = SEL_PC; dp.a_in = 1; tick(); dp.a_in = 0;
    peek(SEL_IMM, 16'hFFFE, "sext_imm");
    alu_op(16'h71FE, ALU_ADD, 16'h000E, "br_target");
    dp.pc_in = 1; tick(); dp.pc_in = 0;
    peek(SEL_PC, 16'h000E, "pc_branch");

    // PC wrap and load-over-increment priority
    load_ir(16'h71FF);
    dp.select = SEL_IMM; dp.r7_in = 1; tick(); dp.r7_in = 0;
    peek(SEL_PC, 16'hFFFF, "pc_ffff");
    dp.pc_inc = 1; tick(); dp.pc_inc = 0;
    peek(SEL_PC, 16'h0000, "pc_wrap");
    dp.select = SEL_DIN; dp.din = 16'h1234; dp.pc_in = 1; dp.pc_inc = 1; tick();
    dp.pc_in = 0; dp.pc_inc = 0;
    peek(SEL_RY, 16'h1234, "pc_prio_ry");

    // store: ADDR<=R2, DOUT<=R3, then write
    dp.select = SEL_DIN; dp.din = 16'h0040; dp.r2_in = 1; tick(); dp.r2_in = 0;
    dp.din = 16'hBEEF; dp.r3_in = 1; tick(); dp.r3_in = 0;
    load_ir(16'h0203);
    dp.select = SEL_RX; dp.addr_in = 1; tick(); dp.addr_in = 0;
    dp.select = SEL_RY; dp.dout_in = 1; tick(); dp.dout_in = 0;
    dp.wren = 1; #1;
    chk("st_w", {15'b0, dp.w}, 16'h0001);
    chk("st_addr", dp.addr, 16'h0040);
    chk("st_dout", dp.dout, 16'hBEEF);
    tick(); dp.wren = 0; #1;
    chk("st_w_off", {15'b0, dp.w}, 16'h0000);

    // mid-run reset with Z set beforehand
    dp.select = SEL_PC; dp.a_in = 1; tick(); dp.a_in = 0;
    alu_op(16'h0000, ALU_SUB, 16'h1234, "pre_rst_g");
    alu_op(16'h0000, ALU_AND, 16'h0000, "pre_rst_z");
    dp.bope = BOP_EQ; #1; chk("pre_rst_eq", {15'b0, dp.btrue}, 16'h0001);
    resetn = 1'b1; #1;
    chk("mrst_btrue_eq", {15'b0, dp.btrue}, 16'h0000);
    chk("mrst_ir", dp.ir, 16'h0000);
    chk("mrst_addr", dp.addr, 16'h0000);
    chk("mrst_dout", dp.dout, 16'h0000);
    peek(SEL_G, 16'h0000, "mrst_g");
    dp.bope = BOP_ALWAYS; #1;
    chk("mrst_btrue_al", {15'b0, dp.btrue}, 16'h0001);
    tick();
    resetn = 1'b0;
    load_ir(16'h0200);
    peek(SEL_RX, 16'h0000, "mrst_r2");
    peek(SEL_PC, 16'h0000, "mrst_pc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
